mem_host_arbiter: RTL and testbench

MEM_HOST_ARBITER -- requirements
Module: mem_host_arbiter

---
 rtl/mem_host_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_host_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_host_arbiter.sv
// mem_host_arbiter: hands a single memory port to either the CPU or the
// external programming port. Ownership changes go through a SWITCH gap of
// SWITCH_GAP idle cycles. An owner clear request goes through a CLEAR state.
// All memory drive outputs are registered, so they appear one cycle after
// the request is accepted.
// Build option MEM_CLR_SEQ_EN: when defined, CLEAR writes zero to every
// address. When undefined, CLEAR is a single cycle that pulses mem_clr.
module mem_host_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int SWITCH_GAP = 2
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              ext_req,
  input  logic              ext_rw,
  input  logic              ext_clr,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic              cpu_clr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_run,
  output logic              mem_en,
  output logic              mem_rw,
  output logic              mem_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {S_EXT, S_CPU, S_SWITCH, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [3:0]        sw_cnt_q, sw_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_clr_q, mem_clr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
`ifdef MEM_CLR_SEQ_EN
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // Select the request signals of the side that currently owns the memory
  logic              in_cpu, in_owner;
  logic              own_req, own_rw, own_clr, acc;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

  assign in_cpu    = (state_q == S_CPU);
  assign in_owner  = (state_q == S_CPU) || (state_q == S_EXT);
  assign own_req   = in_cpu ? cpu_req   : ext_req;
  assign own_rw    = in_cpu ? cpu_rw    : ext_rw;
  assign own_clr   = in_cpu ? cpu_clr   : ext_clr;
  assign own_addr  = in_cpu ? cpu_addr  : ext_addr;
  assign own_wdata = in_cpu ? cpu_wdata : ext_wdata;

  // A clear request wins over a request in the same cycle, so that request is dropped
  assign acc     = reset && in_owner && own_req && !own_clr;
  assign ext_ack = acc && (state_q == S_EXT);
  assign cpu_ack = acc && (state_q == S_CPU);

  assign cpu_run   = (state_q == S_CPU);
  assign busy      = (state_q == S_SWITCH) || (state_q == S_CLEAR);
  assign owner     = owner_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_clr   = mem_clr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state logic and registered memory drive.
  // mem_addr, mem_wdata and mem_rw keep their last value unless a new access is issued.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    sw_cnt_d    = sw_cnt_q;
    mem_en_d    = 1'b0;
    mem_clr_d   = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_CLR_SEQ_EN
    clr_cnt_d   = clr_cnt_q;
`endif
    case (state_q)
      S_EXT, S_CPU: begin
        if (acc) begin
          mem_en_d    = 1'b1;
          mem_rw_d    = own_rw;
          mem_addr_d  = own_addr;
          mem_wdata_d = own_wdata;
        end
        if (own_clr) begin
          state_d = S_CLEAR;
`ifdef MEM_CLR_SEQ_EN
          // The first zero write goes out in the first CLEAR cycle
          clr_cnt_d   = '0;
          mem_en_d    = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
`else
          mem_clr_d   = 1'b1;
`endif
        end else if (cpu_en != owner_q) begin
          // A request accepted this cycle still goes out on the first SWITCH cycle
          state_d  = S_SWITCH;
          sw_cnt_d = '0;
        end
      end
      S_SWITCH: begin
        // cpu_en is not looked at here: the gap always runs to completion
        if (sw_cnt_q == 4'(SWITCH_GAP - 1)) begin
          owner_d  = ~owner_q;
          state_d  = owner_q ? S_EXT : S_CPU;
          sw_cnt_d = '0;
        end else begin
          sw_cnt_d = sw_cnt_q + 4'd1;
        end
      end
      S_CLEAR: begin
`ifdef MEM_CLR_SEQ_EN
        if (clr_cnt_q == '1) begin
          state_d = owner_q ? S_CPU : S_EXT;
        end else begin
          clr_cnt_d   = clr_cnt_q + 1'b1;
          mem_en_d    = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = clr_cnt_q + 1'b1;
          mem_wdata_d = '0;
        end
`else
        state_d = owner_q ? S_CPU : S_EXT;
`endif
      end
      default: state_d = S_EXT;
    endcase
  end

  // State and output registers; reset abandons any SWITCH or CLEAR in progress
  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EXT;
      owner_q     <= 1'b0;
      sw_cnt_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_clr_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_CLR_SEQ_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      sw_cnt_q    <= sw_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_clr_q   <= mem_clr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_CLR_SEQ_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_host_arbiter.sv
// Bench for mem_host_arbiter. Every memory access the bench expects is pushed
// to a queue when the stimulus is driven. A monitor pops and compares an entry
// on every cycle where the memory port is driven. The handshake and status
// outputs are checked inline.
module tb_mem_host_arbiter;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int GAP  = 2;
  localparam int NCLR = 1 << AW;

  logic          main_clk, reset, cpu_en;
  logic          ext_req, ext_rw, ext_clr, ext_ack;
  logic [AW-1:0] ext_addr, cpu_addr, mem_addr;
  logic [DW-1:0] ext_wdata, cpu_wdata, mem_wdata;
  logic          cpu_req, cpu_rw, cpu_clr, cpu_ack, cpu_run;
  logic          mem_en, mem_rw, mem_clr, busy, owner;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          rw;
    logic          clr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  mem_host_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SWITCH_GAP(GAP)) dut (
    .main_clk(main_clk), .reset(reset), .cpu_en(cpu_en),
    .ext_req(ext_req), .ext_rw(ext_rw), .ext_clr(ext_clr),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ack(ext_ack),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_clr(cpu_clr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_run(cpu_run), .mem_en(mem_en), .mem_rw(mem_rw), .mem_clr(mem_clr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .owner(owner)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  // Scoreboard monitor: every driven memory cycle must match the oldest expected access
  always @(negedge main_clk) begin
    if (reset && (mem_en || mem_clr)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got en=%b clr=%b rw=%b addr=%h wdata=%h, want no access",
                 mem_en, mem_clr, mem_rw, mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if (mem_clr !== e.clr || (e.clr && mem_en !== 1'b0) ||
            (!e.clr && (mem_rw !== e.rw || mem_addr !== e.addr || mem_wdata !== e.wd))) begin
          bad++;
          $display("FAIL sb_access: got en=%b clr=%b rw=%b addr=%h wdata=%h, want clr=%b rw=%b addr=%h wdata=%h",
                   mem_en, mem_clr, mem_rw, mem_addr, mem_wdata, e.clr, e.rw, e.addr, e.wd);
        end
      end
    end
  end

  task automatic push_exp(input logic rw, input logic clr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t x;
    x.rw = rw; x.clr = clr; x.addr = a; x.wd = d;
    sb.push_back(x);
  endtask

  // Queue the accesses a CLEAR is expected to produce
  task automatic push_clear();
`ifdef MEM_CLR_SEQ_EN
    for (int k = 0; k < NCLR; k++) push_exp(1'b1, 1'b0, AW'(k), '0);
`else
    push_exp(1'b0, 1'b1, '0, '0);
`endif
  endtask

  task automatic step();
    @(posedge main_clk);
    #1;
  endtask

  task automatic idle();
    ext_req = 0; ext_rw = 0; ext_clr = 0;
    cpu_req = 0; cpu_rw = 0; cpu_clr = 0;
  endtask

  task automatic test_reset();
    reset = 1; cpu_en = 0; idle();
    ext_addr = '0; ext_wdata = '0; cpu_addr = '0; cpu_wdata = '0;
    #3 reset = 0;
    ext_req = 1;
    #1;
    total++; if ({owner, cpu_run, ext_ack, cpu_ack, busy} !== 5'b0) begin bad++;
      $display("FAIL rst_status: got own=%b run=%b eack=%b cack=%b busy=%b, want all 0", owner, cpu_run, ext_ack, cpu_ack, busy); end
    total++; if ({mem_en, mem_rw, mem_clr, mem_addr, mem_wdata} !== '0) begin bad++;
      $display("FAIL rst_mem: got en=%b rw=%b clr=%b addr=%h wd=%h, want 0", mem_en, mem_rw, mem_clr, mem_addr, mem_wdata); end
    step(); step();
    total++; if (mem_en !== 1'b0 || ext_ack !== 1'b0) begin bad++;
      $display("FAIL rst_hold: got en=%b eack=%b, want 0 0", mem_en, ext_ack); end
    ext_req = 0;
    reset = 1;
  endtask

  task automatic test_ext_access();
    step();
    ext_req = 1; ext_rw = 1; ext_addr = 12'h005; ext_wdata = 32'hDEADBEEF;
    cpu_req = 1; cpu_rw = 1; cpu_addr = 12'h0F0;
    #1;
    total++; if (ext_ack !== 1'b1 || cpu_ack !== 1'b0) begin bad++;
      $display("FAIL ext_ack: got eack=%b cack=%b, want 1 0", ext_ack, cpu_ack); end
    total++; if (owner !== 1'b0 || cpu_run !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL ext_status: got own=%b run=%b busy=%b, want 0 0 0", owner, cpu_run, busy); end
    push_exp(1'b1, 1'b0, 12'h005, 32'hDEADBEEF);
    step();
    cpu_req = 0;
    ext_req = 1; ext_rw = 0; ext_addr = 12'h123; ext_wdata = 32'h0000_0042;
    #1;
    total++; if (mem_en !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 12'h005 || mem_wdata !== 32'hDEADBEEF) begin bad++;
      $display("FAIL ext_wr_drive: got en=%b rw=%b addr=%h wd=%h, want 1 1 005 deadbeef", mem_en, mem_rw, mem_addr, mem_wdata); end
    total++; if (ext_ack !== 1'b1) begin bad++; $display("FAIL ext_rd_ack: got %b want 1", ext_ack); end
    push_exp(1'b0, 1'b0, 12'h123, 32'h0000_0042);
    step(); idle();
    #1;
    total++; if (mem_en !== 1'b1 || mem_rw !== 1'b0) begin bad++;
      $display("FAIL ext_rd_drive: got en=%b rw=%b, want 1 0", mem_en, mem_rw); end
    step();
    total++; if (mem_en !== 1'b0 || mem_addr !== 12'h123 || mem_wdata !== 32'h0000_0042) begin bad++;
      $display("FAIL mem_hold: got en=%b addr=%h wd=%h, want 0 123 00000042", mem_en, mem_addr, mem_wdata); end
  endtask

  task automatic test_switch_to_cpu();
    step();
    cpu_en = 1;
    #1;
    total++; if (busy !== 1'b0 || owner !== 1'b0) begin bad++;
      $display("FAIL sw_pre: got busy=%b own=%b, want 0 0", busy, owner); end
    for (int i = 0; i < GAP; i++) begin
      step();
      total++; if (busy !== 1'b1 || mem_en !== 1'b0 || cpu_run !== 1'b0 || owner !== 1'b0) begin bad++;
        $display("FAIL sw_gap%0d: got busy=%b en=%b run=%b own=%b, want 1 0 0 0", i, busy, mem_en, cpu_run, owner); end
    end
    step();
    cpu_req = 1; cpu_rw = 0; cpu_addr = 12'h010; cpu_wdata = 32'h0;
    ext_req = 1; ext_addr = 12'hFFF;
    #1;
    total++; if (owner !== 1'b1 || cpu_run !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL sw_done: got own=%b run=%b busy=%b, want 1 1 0", owner, cpu_run, busy); end
    total++; if (cpu_ack !== 1'b1 || ext_ack !== 1'b0) begin bad++;
      $display("FAIL cpu_ack: got cack=%b eack=%b, want 1 0", cpu_ack, ext_ack); end
    push_exp(1'b0, 1'b0, 12'h010, 32'h0);
    step(); idle();
    #1;
    total++; if (mem_en !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 12'h010) begin bad++;
      $display("FAIL cpu_rd_drive: got en=%b rw=%b addr=%h, want 1 0 010", mem_en, mem_rw, mem_addr); end
  endtask

  // The external port hammers away while the CPU issues back-to-back writes
  task automatic test_cpu_ignores_ext();
    for (int i = 0; i < 10; i++) begin
      step();
      ext_req = 1; ext_rw = 1; ext_addr = AW'(12'h300 + i); ext_wdata = DW'(i);
      cpu_req = (i % 2 == 0); cpu_rw = 1; cpu_addr = AW'(12'h040 + i); cpu_wdata = DW'(32'hC0DE_0000 + i);
      if (i % 2 == 0) push_exp(1'b1, 1'b0, AW'(12'h040 + i), DW'(32'hC0DE_0000 + i));
      #1;
      total++; if (ext_ack !== 1'b0 || cpu_ack !== cpu_req) begin bad++;
        $display("FAIL cpu_excl%0d: got eack=%b cack=%b, want 0 %b", i, ext_ack, cpu_ack, cpu_req); end
    end
    step(); idle();
    step();
  endtask

  // CPU clear with a dropped request. cpu_en drops during the clear, and the
  // switch that follows is interrupted by reset.
  task automatic test_clear();
    step();
    cpu_clr = 1; cpu_req = 1; cpu_rw = 1; cpu_addr = 12'h099;
    #1;
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL clr_drop: got cack=%b want 0", cpu_ack); end
    push_clear();
`ifdef MEM_CLR_SEQ_EN
    for (int k = 0; k < NCLR; k++) begin
      step();
      cpu_clr = 0; cpu_req = 0;
      if (k == 7) cpu_en = 0;
      #1;
      if (busy !== 1'b1 || cpu_run !== 1'b0) begin total++; bad++;
        $display("FAIL clr_busy%0d: got busy=%b run=%b, want 1 0", k, busy, cpu_run); end
      if (k == 7) begin total++; if (mem_addr !== 12'h007) begin bad++;
        $display("FAIL clr_addr7: got %h want 007", mem_addr); end end
    end
    total++;
`else
    step();
    cpu_clr = 0; cpu_req = 0; cpu_en = 0;
    #1;
    total++; if (busy !== 1'b1 || cpu_run !== 1'b0 || mem_clr !== 1'b1 || mem_en !== 1'b0) begin bad++;
      $display("FAIL clr_pulse: got busy=%b run=%b clr=%b en=%b, want 1 0 1 0", busy, cpu_run, mem_clr, mem_en); end
`endif
    step();
    cpu_req = 1; cpu_rw = 1; cpu_addr = 12'h0AA; cpu_wdata = 32'h1234_5678;
    #1;
    total++; if (busy !== 1'b0 || cpu_run !== 1'b1 || owner !== 1'b1 || mem_clr !== 1'b0 || cpu_ack !== 1'b1) begin bad++;
      $display("FAIL clr_exit: got busy=%b run=%b own=%b clr=%b cack=%b, want 0 1 1 0 1", busy, cpu_run, owner, mem_clr, cpu_ack); end
    push_exp(1'b1, 1'b0, 12'h0AA, 32'h1234_5678);
    step(); idle();
    #1;
    total++; if (busy !== 1'b1 || cpu_run !== 1'b0 || mem_en !== 1'b1) begin bad++;
      $display("FAIL sw_tail: got busy=%b run=%b en=%b, want 1 0 1", busy, cpu_run, mem_en); end
    step();
    #1;
    reset = 0;
    #1;
    total++; if (owner !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0 || cpu_run !== 1'b0) begin bad++;
      $display("FAIL rst_mid_sw: got own=%b busy=%b en=%b run=%b, want 0 0 0 0", owner, busy, mem_en, cpu_run); end
    #1 reset = 1;
    step();
    total++; if (owner !== 1'b0 || busy !== 1'b0 || cpu_run !== 1'b0) begin bad++;
      $display("FAIL rst_after: got own=%b busy=%b run=%b, want 0 0 0", owner, busy, cpu_run); end
  endtask

  // External clear, then cpu_en bounces during the switch gap
  task automatic test_ext_clear_bounce();
    step();
    ext_clr = 1; ext_req = 1; ext_addr = 12'h055;
    #1;
    total++; if (ext_ack !== 1'b0) begin bad++; $display("FAIL eclr_drop: got eack=%b want 0", ext_ack); end
    push_clear();
`ifdef MEM_CLR_SEQ_EN
    for (int k = 0; k < NCLR; k++) begin
      step(); idle();
      if (busy !== 1'b1) begin total++; bad++; $display("FAIL eclr_busy%0d: got %b want 1", k, busy); end
    end
    total++;
`else
    step(); idle();
    total++; if (busy !== 1'b1 || mem_clr !== 1'b1) begin bad++;
      $display("FAIL eclr_pulse: got busy=%b clr=%b, want 1 1", busy, mem_clr); end
`endif
    step();
    total++; if (busy !== 1'b0 || owner !== 1'b0) begin bad++;
      $display("FAIL eclr_exit: got busy=%b own=%b, want 0 0", busy, owner); end
    cpu_en = 1;
    step();
    cpu_en = 0;
    total++; if (busy !== 1'b1 || owner !== 1'b0) begin bad++;
      $display("FAIL bnc_sw1: got busy=%b own=%b, want 1 0", busy, owner); end
    step();
    step();
    total++; if (owner !== 1'b1 || cpu_run !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL bnc_cpu: got own=%b run=%b busy=%b, want 1 1 0", owner, cpu_run, busy); end
    step();
    total++; if (busy !== 1'b1 || owner !== 1'b1 || cpu_run !== 1'b0) begin bad++;
      $display("FAIL bnc_sw2: got busy=%b own=%b run=%b, want 1 1 0", busy, owner, cpu_run); end
    step();
    step();
    ext_req = 1; ext_rw = 1; ext_addr = 12'h7FF; ext_wdata = 32'hA5A5_5A5A;
    #1;
    total++; if (owner !== 1'b0 || busy !== 1'b0 || ext_ack !== 1'b1) begin bad++;
      $display("FAIL bnc_ext: got own=%b busy=%b eack=%b, want 0 0 1", owner, busy, ext_ack); end
    push_exp(1'b1, 1'b0, 12'h7FF, 32'hA5A5_5A5A);
    step(); idle();
    step(); step();
  endtask

  initial begin
    test_reset();
    test_ext_access();
    test_switch_to_cpu();
    test_cpu_ignores_ext();
    test_clear();
    test_ext_clear_bounce();
    total++;
    if (sb.size() != 0) begin bad++;
      $display("FAIL sb_leftover: got %0d pending accesses, want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
